// File: rtl/wrr_vc_arbiter_if.sv
// Bundle between the VC FIFO bank and the weighted round-robin arbiter.
// WRR_GRANT_STATS_EN adds the clr_stats / grant_cnt statistics signals.
interface wrr_vc_arbiter_if #(
    parameter int NUM_VC   = 4,
    parameter int DATA_W   = 4,
    parameter int WEIGHT_W = 4
);
    localparam int ID_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    // Handshake: a FIFO is popped in any cycle its pop_vc bit is 1 (no ready,
    // the head word is consumed at that edge); out_valid is high for exactly
    // one cycle per popped word, and out_data/grant_id are meaningful only then.
    logic                       enb;
    logic                       stall;
    logic [NUM_VC-1:0]          empty_vc;
    logic [NUM_VC*DATA_W-1:0]   data_vc;
    logic [NUM_VC*WEIGHT_W-1:0] weight_vc;
    logic [NUM_VC-1:0]          pop_vc;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic [ID_W-1:0]            grant_id;
`ifdef WRR_GRANT_STATS_EN
    logic                       clr_stats;
    logic [NUM_VC*16-1:0]       grant_cnt;

    modport master (
        output enb, stall, empty_vc, data_vc, weight_vc, clr_stats,
        input  pop_vc, out_data, out_valid, grant_id, grant_cnt
    );
    modport slave (
        input  enb, stall, empty_vc, data_vc, weight_vc, clr_stats,
        output pop_vc, out_data, out_valid, grant_id, grant_cnt
    );
`else
    modport master (
        output enb, stall, empty_vc, data_vc, weight_vc,
        input  pop_vc, out_data, out_valid, grant_id
    );
    modport slave (
        input  enb, stall, empty_vc, data_vc, weight_vc,
        output pop_vc, out_data, out_valid, grant_id
    );
`endif
endinterface

// File: rtl/wrr_vc_arbiter.sv
// Weighted round-robin arbiter and registered output mux over NUM_VC VC FIFOs.
// Define WRR_GRANT_STATS_EN for per-channel saturating grant counters.
module wrr_vc_arbiter #(
    parameter int                NUM_VC   = 4,
    parameter int                DATA_W   = 4,
    parameter int                WEIGHT_W = 4,
    parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    wrr_vc_arbiter_if.slave   bus
);
    localparam int ID_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    function automatic logic [WEIGHT_W-1:0] eff_w(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    logic [ID_W-1:0]     ptr;
    logic [WEIGHT_W-1:0] credit;
    logic [ID_W-1:0]     sel;
    logic                any_req;
    logic                grant;
    logic [NUM_VC-1:0]   pop;
    logic [WEIGHT_W-1:0] w_ptr;
    logic [WEIGHT_W-1:0] w_sel;
    logic [ID_W-1:0]     ptr_inc;
    logic [ID_W-1:0]     sel_inc;
    logic                rotate;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic [ID_W-1:0]     grant_id_q;

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = ptr;
        any_req = 1'b0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_VC) idx = idx - NUM_VC;
            if (!bus.empty_vc[idx]) begin
                sel     = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign grant   = rst && bus.enb && !bus.stall && any_req;
    assign pop     = grant ? (NUM_VC'(1) << sel) : '0;
    assign w_ptr   = eff_w(bus.weight_vc[int'(ptr) * WEIGHT_W +: WEIGHT_W]);
    assign w_sel   = eff_w(bus.weight_vc[int'(sel) * WEIGHT_W +: WEIGHT_W]);
    assign ptr_inc = (ptr == ID_W'(NUM_VC - 1)) ? '0 : ptr + ID_W'(1);
    assign sel_inc = (sel == ID_W'(NUM_VC - 1)) ? '0 : sel + ID_W'(1);
    // Compare at WEIGHT_W+1 bits so credit+1 cannot wrap; >= also covers a weight lowered mid-burst.
    assign rotate  = ({1'b0, credit} + (WEIGHT_W + 1)'(1)) >= {1'b0, w_ptr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            credit      <= '0;
            out_data_q  <= IDLE_VAL;
            out_valid_q <= 1'b0;
            grant_id_q  <= '0;
        end else if (bus.enb) begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.data_vc[int'(sel) * DATA_W +: DATA_W];
                grant_id_q  <= sel;
                if (sel == ptr) begin
                    if (rotate) begin
                        ptr    <= ptr_inc;
                        credit <= '0;
                    end else begin
                        credit <= credit + WEIGHT_W'(1);
                    end
                end else if (w_sel == WEIGHT_W'(1)) begin
                    ptr    <= sel_inc;
                    credit <= '0;
                end else begin
                    // The skipped ptr channel forfeits its remaining credit.
                    ptr    <= sel;
                    credit <= WEIGHT_W'(1);
                end
            end else begin
                out_valid_q <= 1'b0;
                out_data_q  <= IDLE_VAL;
            end
        end
    end

    assign bus.pop_vc    = pop;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant_id  = grant_id_q;

`ifdef WRR_GRANT_STATS_EN
    logic [15:0] cnt [NUM_VC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VC; i++) cnt[i] <= '0;
        end else if (bus.clr_stats) begin
            for (int i = 0; i < NUM_VC; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++)
                if (pop[i] && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
        end
    end

    always_comb begin
        bus.grant_cnt = '0;
        for (int i = 0; i < NUM_VC; i++) bus.grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif
endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Directed bench for wrr_vc_arbiter: expected grant order is queued per scenario
// and checked against pop_vc and the registered outputs cycle by cycle.
module tb_wrr_vc_arbiter;
  localparam int NUM_VC   = 4;
  localparam int DATA_W   = 4;
  localparam int WEIGHT_W = 4;
  localparam int ID_W     = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wrr_vc_arbiter_if #(.NUM_VC(NUM_VC), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) bus ();

  wrr_vc_arbiter #(
    .NUM_VC(NUM_VC), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .IDLE_VAL(4'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] dat [NUM_VC] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [ID_W-1:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: entered at posedge+1, leave at the next posedge+1
  task automatic grant_step(input int c);
    #1;
    check("pop_vc", 32'(bus.pop_vc), 32'(1) << c);
    @(posedge clk); #1;
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("grant_id", 32'(bus.grant_id), 32'(c));
    check("out_data", 32'(bus.out_data), 32'(dat[c]));
  endtask

  task automatic idle_step(input logic exp_valid, input logic [DATA_W-1:0] exp_data,
                           input int exp_gid);
    #1;
    check("pop_idle", 32'(bus.pop_vc), 32'd0);
    @(posedge clk); #1;
    check("valid_idle", 32'(bus.out_valid), 32'(exp_valid));
    check("data_idle", 32'(bus.out_data), 32'(exp_data));
    check("gid_idle", 32'(bus.grant_id), 32'(exp_gid));
  endtask

  task automatic drain();
    while (exp_q.size() > 0) grant_step(int'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_pop", 32'(bus.pop_vc), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.enb       = 1'b1;
    bus.stall     = 1'b0;
    bus.empty_vc  = 4'b0000;
    bus.data_vc   = 16'($urandom_range(0, 16'hFFFF));
    bus.weight_vc = 16'($urandom_range(0, 16'hFFFF));
`ifdef WRR_GRANT_STATS_EN
    bus.clr_stats = 1'b0;
`endif
    // reset held with live requests
    repeat (3) @(posedge clk);
    #1;
    check("reset_pop", 32'(bus.pop_vc), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_data", 32'(bus.out_data), 32'd0);
    check("reset_gid", 32'(bus.grant_id), 32'd0);

    bus.data_vc  = {dat[3], dat[2], dat[1], dat[0]};
    bus.empty_vc = 4'b1111;
    rst = 1'b1;
    repeat (3) idle_step(1'b0, 4'h0, 0);

    // equal weights: plain rotation, then enb=0 freezes everything
    bus.weight_vc = 16'h1111;
    bus.empty_vc  = 4'b0000;
    exp_q = '{0, 1, 2, 3, 0};
    drain();
    bus.enb = 1'b0;
    repeat (2) idle_step(1'b1, dat[0], 0);
    bus.enb = 1'b1;
    grant_step(1);

    // weights 3,1,2,0 (0 behaves as 1)
    do_reset();
    bus.weight_vc = 16'h0213;
    exp_q = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    drain();

    // only ch2 requesting, then ch0 joins with ptr=2, credit=1
    do_reset();
    bus.weight_vc = 16'h2222;
    bus.empty_vc  = 4'b1011;
    exp_q = '{2, 2, 2};
    drain();
    bus.empty_vc  = 4'b1010;
    exp_q = '{2, 0, 0, 2};
    drain();

    // stall in the middle of a ch1 burst (w=4, credit=2)
    do_reset();
    bus.weight_vc = 16'h1141;
    bus.empty_vc  = 4'b0000;
    exp_q = '{0, 1, 1};
    drain();
    bus.stall = 1'b1;
    repeat (3) idle_step(1'b0, 4'h0, 1);
    bus.stall = 1'b0;
    exp_q = '{1, 1, 2};
    drain();
    bus.empty_vc = 4'b1111;
    idle_step(1'b0, 4'h0, 2);

    // weight lowered below accumulated credit rotates on the next grant
    do_reset();
    bus.weight_vc = 16'h1114;
    bus.empty_vc  = 4'b0000;
    exp_q = '{0, 0};
    drain();
    bus.weight_vc = 16'h1112;
    exp_q = '{0, 1};
    drain();

`ifdef WRR_GRANT_STATS_EN
    do_reset();
    bus.weight_vc = 16'h1111;
    bus.empty_vc  = 4'b1101;
    repeat (10) grant_step(1);
    check("cnt_ch1", 32'(bus.grant_cnt[16 +: 16]), 32'd10);
    check("cnt_ch0", 32'(bus.grant_cnt[0 +: 16]), 32'd0);
    bus.clr_stats = 1'b1;
    grant_step(1);
    bus.clr_stats = 1'b0;
    check("cnt_clr", 32'(bus.grant_cnt[16 +: 16]), 32'd0);
    grant_step(1);
    check("cnt_after_clr", 32'(bus.grant_cnt[16 +: 16]), 32'd1);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wrr_vc_arbiter.md
Name: wrr_vc_arbiter

Overview:
Parametrised weighted round-robin arbiter and output mux for NUM_VC virtual-channel FIFOs.
- Selects one non-empty channel per cycle and pops it.
- Drives the popped word onto a single registered output toward the downstream stage.
- Each channel gets up to its programmed weight of consecutive grants before the pointer rotates.
- Work-conserving: empty channels are skipped.

Parameters:
NUM_VC, 4, number of virtual channels (2..16)
DATA_W, 4, width of each channel word
WEIGHT_W, 4, width of each per-channel weight field
IDLE_VAL, 0, value driven on out_data in cycles with no grant

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
enb  input  1  arbitration enable; 0 freezes all state and blocks pops
stall  input  1  downstream full; 1 blocks grants this cycle
empty_vc  input  NUM_VC  per-channel FIFO empty flags, bit i = channel i
data_vc  input  NUM_VC*DATA_W  show-ahead head words, channel i at [i*DATA_W +: DATA_W]
weight_vc  input  NUM_VC*WEIGHT_W  per-channel weights, channel i at [i*WEIGHT_W +: WEIGHT_W]
pop_vc  output  NUM_VC  combinational one-hot pop to the granted FIFO
out_data  output  DATA_W  registered granted word
out_valid  output  1  registered, 1 for one cycle per granted word
grant_id  output  clog2(NUM_VC)  registered index of the last granted channel

Behaviour:
- Reset (rst=0, asynchronous):
  - out_data=IDLE_VAL, out_valid=0, grant_id=0.
  - Internal ptr=0, credit=0.
  - pop_vc=0 while rst=0.
- Internal state:
  - ptr: current-priority channel, clog2(NUM_VC) bits.
  - credit: grants already given to ptr, WEIGHT_W bits.
- Effective weight: w(i) = weight_vc[i], with 0 treated as 1.
- Grant condition: rst=1 && enb=1 && stall=0 && at least one empty_vc bit = 0.
- Selection:
  - Search ptr, ptr+1, ... ptr+NUM_VC-1, modulo NUM_VC.
  - The first channel c with empty_vc[c]=0 wins.
  - Pure combinational search; no extra cycle.
- pop_vc[c]=1 in the same cycle as selection, only when the grant condition holds; otherwise pop_vc=0.
- Latency: data_vc of c sampled at the edge ending the pop cycle, visible on out_data one cycle after the pop.
  - Same edge: out_valid<=1, grant_id<=c.
- State update on a grant, c==ptr:
  - If credit+1 >= w(ptr): ptr<=ptr+1 (wrap NUM_VC-1 -> 0), credit<=0.
  - Else: credit<=credit+1.
- State update on a grant, c!=ptr (ptr channel was empty, so its remaining credit is forfeited):
  - If w(c)==1: ptr<=c+1 (mod NUM_VC), credit<=0.
  - Else: ptr<=c, credit<=1.
- No grant because all channels are empty, or stall=1 with enb=1:
  - out_valid<=0, out_data<=IDLE_VAL.
  - grant_id, ptr and credit hold.
- enb=0: all registers hold, including out_valid and out_data; pop_vc=0.
- Weight change mid-burst: takes effect at the next comparison. If credit already >= the new w(ptr), the next grant to ptr rotates.
- Reset mid-burst: immediate clear; no pop is issued in the reset cycle.
- Single non-empty channel: granted every cycle regardless of weight (work-conserving).

Optional Feature:
WRR_GRANT_STATS_EN
- When defined, adds:
  - Input clr_stats (1 bit, synchronous).
  - Output grant_cnt (NUM_VC*16), one saturating 16-bit counter per channel.
  - Each counter increments on every cycle its pop_vc bit is 1 and saturates at 16'hFFFF.
  - clr_stats=1 zeroes all counters at the next edge; clr_stats wins over an increment in the same cycle.
  - Asynchronous reset clears all counters.
- When undefined: no port, no counters; arbitration behaviour is identical.

Test Plan:
- Reset: drive rst=0 with random inputs -> out_data=0, out_valid=0, grant_id=0, pop_vc=0; after release with all empty_vc=1 -> no pops, out_valid stays 0.
- Weights 1/1/1/1, all channels non-empty, stall=0 -> pop_vc 0001,0010,0100,1000,0001...; grant_id one cycle behind: 0,1,2,3,0.
- Weights ch0=3, ch1=1, ch2=2, ch3=0, all non-empty -> grant order 0,0,0,1,2,2,3,0,0,0... (weight 0 gives one grant).
- Weights all 2, only ch2 non-empty -> ch2 granted every cycle. Then make ch0 non-empty with ptr on ch2 and credit=1 -> one more ch2 grant, then ch3 skipped, then ch0,ch0.
- stall=1 for 3 cycles during a ch1 burst (w=4, credit=2) -> pop_vc=0 and out_valid=0 for 3 cycles. After release, ch1 gets exactly 2 more grants before rotating.
- With WRR_GRANT_STATS_EN defined: 10 grants to ch1 -> grant_cnt[ch1]=10. Assert clr_stats in the same cycle as a ch1 grant -> count reads 0.
